ldtu_word_buffer: RTL and testbench

//  Downstream stage of the LiTe-DTU encoder. Takes 32-bit words from the normal stream (data_in/load)
//  or the fallback stream (data_fb/load_fb), selected by the fallback input. Buffers the words in a

---
 rtl/ldtu_word_buffer.sv | 101 ++++++++++
 tb/tb_ldtu_word_buffer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ldtu_word_buffer.sv
// LiTe-DTU output word buffer: selects the normal or fallback stream, queues words in a small FIFO,
// inserts a marker on each mode change and feeds the serializer, substituting IDLE_WORD when empty.
module ldtu_word_buffer #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AW          = 3,
  parameter logic [31:0] IDLE_WORD   = 32'hEAAAAAAA,
  parameter logic [31:0] MARK_NORMAL = 32'hF0F0F0F0,
  parameter logic [31:0] MARK_FB     = 32'h0F0F0F0F
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fallback,
  input  logic [31:0]   data_in,
  input  logic          load,
  input  logic [31:0]   data_fb,
  input  logic          load_fb,
  input  logic          ser_ready,
  input  logic          ovf_clr,
  output logic [31:0]   ser_data,
  output logic          ser_strobe,
  output logic          ser_idle,
  output logic [AW:0]   level,
  output logic          overflow
);

  localparam int unsigned DW         = 32;
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic {RUN = 1'b0, MARK = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, push, push_ok, rd_en, mark_drop, drop;
  logic [DW-1:0] wr_data, push_data;

  // Next-state, push source selection and FIFO accept/drop decisions
  always_comb begin
    wr_en     = fallback ? load_fb : load;
    wr_data   = fallback ? data_fb : data_in;
    state_d   = state_q;
    mode_d    = mode_q;
    push      = wr_en;
    push_data = wr_data;
    mark_drop = 1'b0;
    case (state_q)
      RUN: begin
        if (fallback != mode_q) begin
          state_d = MARK;
          mode_d  = fallback;
        end
      end
      MARK: begin
        push      = 1'b1;
        push_data = mode_q ? MARK_FB : MARK_NORMAL;
        mark_drop = wr_en;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
    rd_en   = ser_ready && (level != '0);
    // A read in the same cycle frees a slot, so a full FIFO still accepts the push
    push_ok = push && ((level != FULL_LEVEL) || rd_en);
    drop    = (push && !push_ok) || mark_drop;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      mode_q     <= fallback;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      ser_data   <= IDLE_WORD;
      ser_strobe <= 1'b0;
      ser_idle   <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      ser_strobe <= ser_ready;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en)   rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !rd_en)      level <= level + (AW+1)'(1);
      else if (!push_ok && rd_en) level <= level - (AW+1)'(1);
      if (ser_ready) begin
        ser_data <= rd_en ? mem[rd_ptr] : IDLE_WORD;
        ser_idle <= !rd_en;
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Storage array, no reset needed: pointers define validity
  always_ff @(posedge clk) begin
    if (reset && push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_ldtu_word_buffer.sv
// Directed bench for ldtu_word_buffer: stimulus queues expected serializer words, a negedge monitor
// pops and compares them whenever ser_strobe is seen; state outputs are checked directly.
module tb_ldtu_word_buffer;

  localparam logic [31:0] IDLE = 32'hEAAAAAAA;
  localparam logic [31:0] MNRM = 32'hF0F0F0F0;
  localparam logic [31:0] MFB  = 32'h0F0F0F0F;

  logic        clk = 1'b0;
  logic        reset, fallback, load, load_fb, ser_ready, ovf_clr;
  logic [31:0] data_in, data_fb, ser_data;
  logic        ser_strobe, ser_idle, overflow;
  logic [3:0]  level;

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  ldtu_word_buffer dut (
    .clk(clk), .reset(reset), .fallback(fallback), .data_in(data_in), .load(load),
    .data_fb(data_fb), .load_fb(load_fb), .ser_ready(ser_ready), .ovf_clr(ovf_clr),
    .ser_data(ser_data), .ser_strobe(ser_strobe), .ser_idle(ser_idle),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one serializer request and record the word it must return
  task automatic req(input logic [31:0] d, input logic idle);
    ser_ready = 1'b1;
    exp_q.push_back({idle, d});
    cyc();
    ser_ready = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d);
    load = 1'b1;
    data_in = d;
    cyc();
    load = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest outstanding request
  always @(negedge clk) begin
    if (ser_strobe === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got data %h idle %b, no request outstanding", ser_data, ser_idle);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({ser_idle, ser_data} !== e) begin
          n_err++;
          $display("FAIL ser_word: got idle %b data %h expected idle %b data %h",
                   ser_idle, ser_data, e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; fallback = 1'b0; load = 1'b0; load_fb = 1'b0;
    ser_ready = 1'b0; ovf_clr = 1'b0; data_in = '0; data_fb = '0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();

    // Reset state
    check("rst_data", ser_data, IDLE);
    check("rst_idle", 32'(ser_idle), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_strobe", 32'(ser_strobe), 32'd0);

    // Single word, then empty read gives IDLE
    push_word(32'h12345678);
    check("one_level", 32'(level), 32'd1);
    req(32'h12345678, 1'b0);
    check("one_level_after", 32'(level), 32'd0);
    cyc();
    check("hold_data", ser_data, 32'h12345678);
    req(IDLE, 1'b1);

    // Fill past full: 9th word dropped
    for (int i = 0; i < 9; i++) push_word(32'hA0 + 32'(i));
    check("full_level", 32'(level), 32'd8);
    check("full_ovf", 32'(overflow), 32'd1);
    load = 1'b1; data_in = 32'hDEAD; ovf_clr = 1'b1;
    cyc();
    load = 1'b0; ovf_clr = 1'b0;
    check("set_wins", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Full with simultaneous read and write
    load = 1'b1; data_in = 32'hB0;
    req(32'hA0, 1'b0);
    load = 1'b0;
    check("full_rw_level", 32'(level), 32'd8);
    check("full_rw_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 8; i++) req(32'hA0 + 32'(i), 1'b0);
    req(32'hB0, 1'b0);
    check("drained", 32'(level), 32'd0);

    // Mode change 0->1 mid-burst
    push_word(32'hC0);
    fallback = 1'b1; load_fb = 1'b1; data_fb = 32'hD0;
    cyc();
    load_fb = 1'b0;
    load = 1'b1; data_in = 32'hC1;
    cyc();
    load_fb = 1'b1; data_fb = 32'hD2; data_in = 32'hC2;
    cyc();
    load = 1'b0; load_fb = 1'b0;
    check("fb_level", 32'(level), 32'd4);
    check("fb_ovf", 32'(overflow), 32'd0);

    // Mode change 1->0 with a word lost in the marker cycle
    fallback = 1'b0; load = 1'b1; data_in = 32'hC3;
    cyc();
    data_in = 32'hC4;
    cyc();
    load = 1'b0;
    check("nrm_level", 32'(level), 32'd6);
    check("nrm_ovf", 32'(overflow), 32'd1);
    req(32'hC0, 1'b0);
    req(32'hD0, 1'b0);
    req(MFB, 1'b0);
    req(32'hD2, 1'b0);
    req(32'hC3, 1'b0);
    check("mark_level", 32'(level), 32'd1);
    req(MNRM, 1'b0);
    check("mark_empty", 32'(level), 32'd0);

    // Reset mid-operation with level 5
    for (int i = 0; i < 5; i++) push_word(32'hE0 + 32'(i));
    check("pre_rst_level", 32'(level), 32'd5);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_data", ser_data, IDLE);
    req(IDLE, 1'b1);
    cyc(); cyc();

    check("pending_reqs", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
